cpu_bus_arbiter: RTL and testbench
==================================

# cpu_bus_arbiter

Two-master arbiter that shares the single cpu32e2-style memory bus (read/write/bwe/address/dataOut in; waitRequest/readValid/dataIn back) between master 0 (CPU) and master 1 (DMA/debug injector). It forwards one master's command per cycle to the slave, holds the grant across slave wait states, and tracks outstanding pipelined reads so each in-order `readValid` beat is routed to the master that issued it. It sits between the masters and the memory/interconnect slave port.

## Interface
- `MAX_PENDING`, 4: outstanding reads tracked. Power of two, 2..16.
- `ADDR_W`, 32: address width.
- `clk` in 1: single clock, posedge.
- `reset` in 1: synchronous, active-high.
- `m_read` in [1:0]: per-master read request.
- `m_write` in [1:0]: per-master write request.
- `m_bwe` in [1:0][3:0]: per-master byte write enables.
- `m_address` in [1:0][ADDR_W-1:0]: per-master byte address.
- `m_dataOut` in [1:0][31:0]: per-master write data.
- `m_waitRequest` out [1:0]: command not accepted this cycle.
- `m_readValid` out [1:0]: read data valid for that master.
- `m_dataIn` out 32: `s_dataIn`, broadcast to both masters.
- `s_read` out 1, `s_write` out 1, `s_bwe` out 4, `s_address` out ADDR_W, `s_dataOut` out 32: forwarded command.
- `s_waitRequest` in 1: slave stall.
- `s_readValid` in 1: slave read data valid, in issue order.
- `s_dataIn` in 32: slave read data.
- `orphanError` out 1: sticky; `s_readValid` arrived with nothing pending.

## Operation
- Request: `req[i] = m_read[i] | m_write[i]`. Both asserted on one master: read is forwarded and `s_write`=0.
- Owner: if `locked`, owner = `grant`. Otherwise, with one requester, that requester. With both, `~lastServed` (round robin).
- Forwarding: owner's command drives `s_*`. `s_read` is gated to 0 when the pending FIFO is full. Non-owner sees `m_waitRequest`=1.
- Accept: `accept = (s_read|s_write) & ~s_waitRequest`. Owner's `m_waitRequest = ~accept`.
- A stalled read caused by a full FIFO also gives owner `m_waitRequest`=1. The owner keeps the grant (lock).
- Lock: set when owner requests and is not accepted. Cleared on accept.
- `lastServed` is set to the owner on every accept.
- Pending FIFO: 1-bit master IDs.
  - Push owner ID on an accepted read.
  - Pop on `s_readValid`.
  - `m_readValid[head] = s_readValid`.
- Full: push blocked even if a pop occurs in the same cycle. Simultaneous push and pop when not full leaves the count unchanged.
- Empty: `s_readValid` is ignored, `m_readValid`=0, and `orphanError` is set.
- Writes never touch the FIFO and may be accepted while reads are pending.

## Timing
- Commands and `m_waitRequest`: combinational, zero-cycle path from master to slave.
- Read-return routing: combinational, zero-cycle, from `s_readValid` to `m_readValid`.
- Registered state: `grant`, `locked`, `lastServed`, FIFO pointers and count, `orphanError`. All update on posedge.
- Reset values while `reset`=1:
  - `s_read`=`s_write`=0.
  - `m_waitRequest`=2'b11.
  - `m_readValid`=0.
  - FIFO empty, `locked`=0, `lastServed`=1 (master 0 wins first), `orphanError`=0.
- Reset mid-transfer: all pending IDs are discarded. Read beats arriving after reset with an empty FIFO set `orphanError`.
- Maximum throughput: one accepted command per cycle. Two contending masters alternate every accept.

## Structure
- Package `cpu_bus_arbiter_pkg`:
  - typedef `busCmd` struct {read, write, bwe[3:0], address, data[31:0]}.
  - typedef `masterId` (1-bit).
  - constant `NUM_MASTERS`=2.
- Sub-module `pending_id_fifo`: parameterised depth, width-1 circular buffer. Provides push, pop, full, empty, head, and a count of width $clog2(MAX_PENDING)+1. Pointers wrap modulo depth.
- Top: owner/lock logic, output muxing, orphan flag.

## Test plan
- Single master: m0 reads 0x100, slave returns `s_readValid` 3 cycles later with data 0xDEADBEEF. Required: `m_waitRequest[0]`=0 in the issue cycle; `m_readValid[0]`=1 with data 0xDEADBEEF; `m_readValid[1]`=0.
- Contention: m0 and m1 both write continuously with no slave stall. Required: accepts alternate m0, m1, m0, …; first accept goes to m0 after reset.
- Lock: m1 granted; `s_waitRequest`=1 for 3 cycles while m0 also requests. Required: `s_address` stays m1's for all 4 cycles; m1 is accepted on cycle 4; m0 is accepted next.
- Full FIFO, MAX_PENDING=4: issue 5 reads with no return. Required: 5th has `s_read`=0 and `m_waitRequest`=1. After one `s_readValid`, the 5th is accepted on the next cycle. Returns route in issue order across mixed master IDs.
- Orphan and reset: `s_readValid`=1 with empty FIFO. Required: `orphanError`=1 next cycle, `m_readValid`=0. Then assert `reset` with 2 reads pending. Required: FIFO empty and `orphanError`=0 after reset.

Source files
------------

// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types for the two-master cpu32e2 bus arbiter.
package cpu_bus_arbiter_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int MAX_ADDR_W  = 64;

    typedef logic masterId;

    // Address is carried at the widest supported width; the top slices it back down.
    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [3:0]            bwe;
        logic [MAX_ADDR_W-1:0] address;
        logic [31:0]           data;
    } busCmd;

    function automatic logic [NUM_MASTERS-1:0] idToOneHot(input masterId id);
        return NUM_MASTERS'(1) << id;
    endfunction

endpackage

// File: rtl/cpu_bus_arbiter_pending_fifo.sv
// Circular buffer of master IDs for reads that are issued but not yet returned.
module pending_id_fifo
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  masterId                  pushId,
    output masterId                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    masterId        mem [DEPTH];
    logic [PW-1:0]  wrPtr;
    logic [PW-1:0]  rdPtr;
    logic           doPush;
    logic           doPop;

    // A full buffer refuses a push even when a pop frees a slot in the same cycle.
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;
    assign full   = (count == (PW + 1)'(DEPTH));
    assign empty  = (count == '0);
    assign head   = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushId;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares one cpu32e2 memory bus between CPU (master 0) and DMA/debug (master 1),
// routing in-order read returns back to the master that issued each read.
module cpu_bus_arbiter
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int MAX_PENDING = 4,
    parameter int ADDR_W      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             m_read,
    input  logic [1:0]             m_write,
    input  logic [1:0][3:0]        m_bwe,
    input  logic [1:0][ADDR_W-1:0] m_address,
    input  logic [1:0][31:0]       m_dataOut,
    output logic [1:0]             m_waitRequest,
    output logic [1:0]             m_readValid,
    output logic [31:0]            m_dataIn,
    output logic                   s_read,
    output logic                   s_write,
    output logic [3:0]             s_bwe,
    output logic [ADDR_W-1:0]      s_address,
    output logic [31:0]            s_dataOut,
    input  logic                   s_waitRequest,
    input  logic                   s_readValid,
    input  logic [31:0]            s_dataIn,
    output logic                   orphanError
);

    // Handshake: a command transfers in any cycle where (s_read | s_write) is high and
    // s_waitRequest is low; the owning master sees m_waitRequest low in exactly that cycle
    // and must hold its command stable until then. Read data has no back-pressure.

    logic [1:0]               req;
    masterId                  owner;
    masterId                  grant;
    masterId                  lastServed;
    logic                     locked;
    logic                     ownerReq;
    busCmd                    cmd [NUM_MASTERS];
    busCmd                    sel;
    logic                     fwdRead;
    logic                     fwdWrite;
    logic                     accept;
    logic                     fifoFull;
    logic                     fifoEmpty;
    masterId                  headId;
    logic [$clog2(MAX_PENDING):0] pendingCount;
    logic                     unusedBits;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cmd[i].read    = m_read[i];
            cmd[i].write   = m_write[i];
            cmd[i].bwe     = m_bwe[i];
            cmd[i].address = MAX_ADDR_W'(m_address[i]);
            cmd[i].data    = m_dataOut[i];
        end
    end

    always_comb begin
        req = m_read | m_write;
        if (locked) begin
            owner = grant;
        end else begin
            case (req)
                2'b01:   owner = 1'b0;
                2'b10:   owner = 1'b1;
                default: owner = ~lastServed;
            endcase
        end
    end

    assign sel      = cmd[owner];
    assign ownerReq = req[owner];

    // Read wins over a simultaneous write from the same master.
    assign fwdRead  = sel.read & ~fifoFull & ~reset;
    assign fwdWrite = sel.write & ~sel.read & ~reset;
    assign accept   = (fwdRead | fwdWrite) & ~s_waitRequest;

    assign s_read    = fwdRead;
    assign s_write   = fwdWrite;
    assign s_bwe     = sel.bwe;
    assign s_address = sel.address[ADDR_W-1:0];
    assign s_dataOut = sel.data;
    assign m_dataIn  = s_dataIn;

    always_comb begin
        m_waitRequest        = 2'b11;
        m_waitRequest[owner] = ~accept;
    end

    assign m_readValid = (s_readValid & ~fifoEmpty & ~reset) ? idToOneHot(headId) : 2'b00;

    pending_id_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_pendingFifo (
        .clk    (clk),
        .reset  (reset),
        .push   (fwdRead & accept),
        .pop    (s_readValid),
        .pushId (owner),
        .head   (headId),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (pendingCount)
    );

    assign unusedBits = ^{sel.address, pendingCount};

    always_ff @(posedge clk) begin
        if (reset) begin
            grant       <= 1'b0;
            locked      <= 1'b0;
            lastServed  <= 1'b1;
            orphanError <= 1'b0;
        end else begin
            // Lock only while the owner is still asking; dropping the request frees the bus.
            locked <= ownerReq & ~accept;
            if (ownerReq) begin
                grant <= owner;
            end
            if (accept) begin
                lastServed <= owner;
            end
            if (s_readValid & fifoEmpty) begin
                orphanError <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter with a decoupled accept/read-return scoreboard.
module tb_cpu_bus_arbiter;

    localparam int AW = 32;
    localparam int MP = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         m_read;
    logic [1:0]         m_write;
    logic [1:0][3:0]    m_bwe;
    logic [1:0][AW-1:0] m_address;
    logic [1:0][31:0]   m_dataOut;
    logic [1:0]         m_waitRequest;
    logic [1:0]         m_readValid;
    logic [31:0]        m_dataIn;
    logic               s_read;
    logic               s_write;
    logic [3:0]         s_bwe;
    logic [AW-1:0]      s_address;
    logic [31:0]        s_dataOut;
    logic               s_waitRequest;
    logic               s_readValid;
    logic [31:0]        s_dataIn;
    logic               orphanError;

    int checks = 0;
    int errors = 0;

    // {grant one-hot, read, write, address} per accepted command
    logic [35:0] expQ[$];
    // {m_readValid one-hot, data} per routed read beat
    logic [33:0] expRdQ[$];

    always #5 clk = ~clk;

    cpu_bus_arbiter #(
        .MAX_PENDING (MP),
        .ADDR_W      (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_bwe         (m_bwe),
        .m_address     (m_address),
        .m_dataOut     (m_dataOut),
        .m_waitRequest (m_waitRequest),
        .m_readValid   (m_readValid),
        .m_dataIn      (m_dataIn),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_bwe         (s_bwe),
        .s_address     (s_address),
        .s_dataOut     (s_dataOut),
        .s_waitRequest (s_waitRequest),
        .s_readValid   (s_readValid),
        .s_dataIn      (s_dataIn),
        .orphanError   (orphanError)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_read        = 2'b00;
        m_write       = 2'b00;
        s_readValid   = 1'b0;
        s_waitRequest = 1'b0;
    endtask

    task automatic setMaster(input int m, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d);
        m_read[m]    = rd;
        m_write[m]   = wr;
        m_address[m] = a;
        m_dataOut[m] = d;
        m_bwe[m]     = 4'hF;
    endtask

    task automatic expAcc(input logic [1:0] oh, input logic rd, input logic wr,
                          input logic [31:0] a);
        expQ.push_back({oh, rd, wr, a});
    endtask

    task automatic expRd(input logic [1:0] oh, input logic [31:0] d);
        expRdQ.push_back({oh, d});
    endtask

    // Monitor: pops an expectation whenever the DUT transfers a command or routes a beat.
    always @(negedge clk) begin : monitor
        logic [35:0] accAct;
        logic [33:0] rdAct;
        if ((s_read | s_write) && !s_waitRequest) begin
            accAct = {~m_waitRequest, s_read, s_write, s_address};
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL accept_unexpected: got %0h required none", accAct);
            end else begin
                chk("accept", accAct, expQ.pop_front());
            end
        end
        if (m_readValid != 2'b00) begin
            rdAct = {m_readValid, m_dataIn};
            if (expRdQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL readvalid_unexpected: got %0h required none", rdAct);
            end else begin
                chk("read_route", rdAct, expRdQ.pop_front());
            end
        end
    end

    initial begin
        logic [1:0] rdMst [5];
        logic [31:0] rdData [5];
        rdMst  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        rdData = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333, 32'hA4A4_4444};

        // Reset with requests and a stray beat present: everything must be gated.
        reset     = 1'b1;
        m_bwe     = '0;
        m_address = '0;
        m_dataOut = '0;
        s_dataIn  = 32'h0;
        idle();
        m_read      = 2'b11;
        s_readValid = 1'b1;
        nextCycle();
        @(negedge clk);
        chk("reset_s_read", s_read, 1'b0);
        chk("reset_s_write", s_write, 1'b0);
        chk("reset_m_wait", m_waitRequest, 2'b11);
        chk("reset_m_readValid", m_readValid, 2'b00);
        chk("reset_orphan", orphanError, 1'b0);
        nextCycle();
        reset = 1'b0;
        idle();

        // Contention: both write continuously, m0 first then alternating.
        setMaster(0, 1'b0, 1'b1, 32'h200, 32'h1111_0000);
        setMaster(1, 1'b0, 1'b1, 32'h300, 32'h2222_0000);
        expAcc(2'b01, 1'b0, 1'b1, 32'h200);
        expAcc(2'b10, 1'b0, 1'b1, 32'h300);
        expAcc(2'b01, 1'b0, 1'b1, 32'h200);
        expAcc(2'b10, 1'b0, 1'b1, 32'h300);
        repeat (4) nextCycle();
        idle();

        // Single read from m0, data returned three cycles later.
        setMaster(0, 1'b1, 1'b0, 32'h100, 32'h0);
        expAcc(2'b01, 1'b1, 1'b0, 32'h100);
        @(negedge clk);
        chk("single_issue_wait0", m_waitRequest[0], 1'b0);
        nextCycle();
        idle();
        nextCycle();
        nextCycle();
        s_readValid = 1'b1;
        s_dataIn    = 32'hDEAD_BEEF;
        expRd(2'b01, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("single_readValid", m_readValid, 2'b01);
        nextCycle();
        idle();

        // Lock: m1 wins (m0 served last), slave stalls three cycles.
        setMaster(0, 1'b0, 1'b1, 32'h500, 32'h5555_5555);
        setMaster(1, 1'b0, 1'b1, 32'h400, 32'h4444_4444);
        s_waitRequest = 1'b1;
        expAcc(2'b10, 1'b0, 1'b1, 32'h400);
        expAcc(2'b01, 1'b0, 1'b1, 32'h500);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) s_waitRequest = 1'b0;
            @(negedge clk);
            chk("lock_addr", s_address, 32'h400);
            if (c < 3) chk("lock_wait", m_waitRequest, 2'b11);
            nextCycle();
        end
        m_write[1] = 1'b0;
        @(negedge clk);
        chk("lock_m0_next", m_waitRequest, 2'b10);
        nextCycle();
        idle();

        // Full FIFO: four reads from alternating masters, fifth stalls until a pop.
        for (int i = 0; i < 4; i++) begin
            idle();
            setMaster(rdMst[i][1] ? 1 : 0, 1'b1, 1'b0, 32'h600 + 32'(i * 4), 32'h0);
            expAcc(rdMst[i], 1'b1, 1'b0, 32'h600 + 32'(i * 4));
            nextCycle();
        end
        idle();
        setMaster(0, 1'b1, 1'b0, 32'h610, 32'h0);
        @(negedge clk);
        chk("full_s_read", s_read, 1'b0);
        chk("full_wait0", m_waitRequest[0], 1'b1);
        nextCycle();
        s_readValid = 1'b1;
        s_dataIn    = rdData[0];
        expRd(rdMst[0], rdData[0]);
        @(negedge clk);
        chk("full_pop_still_blocked", s_read, 1'b0);
        nextCycle();
        s_readValid = 1'b0;
        expAcc(2'b01, 1'b1, 1'b0, 32'h610);
        @(negedge clk);
        chk("full_fifth_accept", m_waitRequest[0], 1'b0);
        nextCycle();
        idle();
        for (int j = 1; j < 5; j++) begin
            s_readValid = 1'b1;
            s_dataIn    = rdData[j];
            expRd(rdMst[j], rdData[j]);
            nextCycle();
        end
        idle();

        // Orphan beat with an empty FIFO.
        s_readValid = 1'b1;
        s_dataIn    = 32'h0000_0BAD;
        @(negedge clk);
        chk("orphan_no_route", m_readValid, 2'b00);
        chk("orphan_not_yet", orphanError, 1'b0);
        nextCycle();
        idle();
        @(negedge clk);
        chk("orphan_set", orphanError, 1'b1);

        // Two reads pending, then reset discards them.
        setMaster(0, 1'b1, 1'b0, 32'h700, 32'h0);
        expAcc(2'b01, 1'b1, 1'b0, 32'h700);
        nextCycle();
        idle();
        setMaster(1, 1'b1, 1'b0, 32'h704, 32'h0);
        expAcc(2'b10, 1'b1, 1'b0, 32'h704);
        nextCycle();
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_wait", m_waitRequest, 2'b11);
        nextCycle();
        reset       = 1'b0;
        s_readValid = 1'b1;
        s_dataIn    = 32'hCAFE_0001;
        @(negedge clk);
        chk("post_reset_orphan_clear", orphanError, 1'b0);
        chk("post_reset_fifo_empty", m_readValid, 2'b00);
        nextCycle();
        idle();
        @(negedge clk);
        chk("post_reset_orphan_set", orphanError, 1'b1);

        // Fresh read after reset routes from an empty FIFO start.
        setMaster(1, 1'b1, 1'b0, 32'h800, 32'h0);
        expAcc(2'b10, 1'b1, 1'b0, 32'h800);
        nextCycle();
        idle();
        s_readValid = 1'b1;
        s_dataIn    = 32'h1234_5678;
        expRd(2'b10, 32'h1234_5678);
        nextCycle();
        idle();
        nextCycle();
        nextCycle();

        chk("accept_queue_drained", 64'(expQ.size()), 64'd0);
        chk("read_queue_drained", 64'(expRdQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
